// File: rtl/serdes_8b_loop.sv
// serdes_8b_loop: byte serializer and matching deserializer sharing one clock.
//
// The serializer sends each byte MSB first, holding every bit for OVERSAMPLE
// clocks, and reloads data_in back-to-back while enable stays high. The
// deserializer samples its serial input once per bit at SAMPLE_PHASE and
// publishes each completed byte with a one-clock des_valid pulse. There is no
// framing recovery: des_enable must rise the clock after enable.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   data_in      parallel byte, sampled at each byte load
//   enable       serializer enable
//   data_out     serial line, MSB first
//   ser_frame    high while data_out carries bit 7 of a byte
//   des_data_in  deserializer serial input (normally data_out)
//   des_enable   deserializer enable
//   des_data_out last fully received byte
//   des_valid    one-clock pulse when des_data_out updates
module serdes_8b_loop #(
  parameter int unsigned OVERSAMPLE   = 1,
  parameter int unsigned SAMPLE_PHASE = OVERSAMPLE / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       enable,
  output logic       data_out,
  output logic       ser_frame,
  input  logic       des_data_in,
  input  logic       des_enable,
  output logic [7:0] des_data_out,
  output logic       des_valid
);

  localparam int unsigned PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PW-1:0] PHASE_LAST   = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_PHASE);

  // ---------------------------------------------------------------- serializer
  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

  ser_state_t    state, state_nx;
  logic [7:0]    ser_shreg;
  logic [2:0]    ser_bit;
  logic [PW-1:0] ser_phase;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (enable)  state_nx = S_SHIFT;
      S_SHIFT: if (!enable) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ser_shreg <= '0;
      ser_bit   <= '0;
      ser_phase <= '0;
    end else if (enable) begin
      if (state == S_IDLE) begin
        ser_shreg <= data_in;
        ser_bit   <= '0;
        ser_phase <= '0;
      end else if (ser_phase == PHASE_LAST) begin
        ser_phase <= '0;
        ser_bit   <= ser_bit + 3'd1;
        // Reload on the last clock of bit 0 so the next byte follows with no gap.
        if (ser_bit == 3'd7) ser_shreg <= data_in;
        else                 ser_shreg <= {ser_shreg[6:0], 1'b0};
      end else begin
        ser_phase <= ser_phase + PW'(1);
      end
    end
  end

  always_comb begin
    data_out  = 1'b0;
    ser_frame = 1'b0;
    if (state == S_SHIFT) begin
      data_out  = ser_shreg[7];
      ser_frame = (ser_bit == 3'd0);
    end
  end

  // -------------------------------------------------------------- deserializer
  logic          des_en_q;
  logic          des_rise;
  logic [PW-1:0] des_phase, eff_phase;
  logic [2:0]    des_bit, eff_bit;
  logic [7:0]    des_shreg, des_shreg_nx;
  logic          capture, bit_end;

  // The clock in which des_enable first reads high is already phase 0 of bit 7,
  // so the counters are treated as cleared combinationally in that clock.
  always_comb begin
    des_rise     = des_enable & ~des_en_q;
    eff_phase    = des_rise ? '0 : des_phase;
    eff_bit      = des_rise ? '0 : des_bit;
    capture      = des_enable && (eff_phase == PHASE_SAMPLE);
    bit_end      = des_enable && (eff_phase == PHASE_LAST);
    des_shreg_nx = capture ? {des_shreg[6:0], des_data_in} : des_shreg;
  end

  // Capture happens at SAMPLE_PHASE; the bit counter advances and the byte is
  // published on the last phase of the bit, which keeps bytes exactly
  // 8*OVERSAMPLE clocks apart from the des_enable rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      des_en_q     <= 1'b0;
      des_phase    <= '0;
      des_bit      <= '0;
      des_shreg    <= '0;
      des_data_out <= '0;
      des_valid    <= 1'b0;
    end else begin
      des_en_q  <= des_enable;
      des_valid <= 1'b0;
      if (des_enable) begin
        des_shreg <= des_shreg_nx;
        if (bit_end) begin
          des_phase <= '0;
          des_bit   <= eff_bit + 3'd1;
          if (eff_bit == 3'd7) begin
            des_data_out <= des_shreg_nx;
            des_valid    <= 1'b1;
          end
        end else begin
          des_phase <= eff_phase + PW'(1);
          des_bit   <= eff_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_serdes_8b_loop.sv
// Bench for serdes_8b_loop: one loop-backed instance at OVERSAMPLE=1 and one
// at OVERSAMPLE=4. Expected received bytes go into a per-instance queue when
// the stimulus is driven; a negedge monitor pops and compares on des_valid.
module tb_serdes_8b_loop;

  logic clock;
  int   total = 0;
  int   bad   = 0;

  logic       rst1, en1, den1, dout1, frm1, dv1;
  logic [7:0] din1, dby1;
  logic       rst4, en4, den4, dout4, frm4, dv4;
  logic [7:0] din4, dby4;

  logic [7:0] q1[$];
  logic [7:0] q4[$];

  serdes_8b_loop #(.OVERSAMPLE(1)) u_os1 (
    .clock(clock), .reset(rst1), .data_in(din1), .enable(en1),
    .data_out(dout1), .ser_frame(frm1), .des_data_in(dout1),
    .des_enable(den1), .des_data_out(dby1), .des_valid(dv1)
  );

  serdes_8b_loop #(.OVERSAMPLE(4)) u_os4 (
    .clock(clock), .reset(rst4), .data_in(din4), .enable(en4),
    .data_out(dout4), .ser_frame(frm4), .des_data_in(dout4),
    .des_enable(den4), .des_data_out(dby4), .des_valid(dv4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rst(input int s, input logic v);
    if (s == 0) rst1 = v; else rst4 = v;
  endtask
  task automatic set_en(input int s, input logic v);
    if (s == 0) en1 = v; else en4 = v;
  endtask
  task automatic set_den(input int s, input logic v);
    if (s == 0) den1 = v; else den4 = v;
  endtask
  task automatic set_din(input int s, input logic [7:0] v);
    if (s == 0) din1 = v; else din4 = v;
  endtask

  // {data_out, ser_frame, des_valid, des_data_out}
  function automatic logic [10:0] obs(input int s);
    if (s == 0) return {dout1, frm1, dv1, dby1};
    return {dout4, frm4, dv4, dby4};
  endfunction

  // Checks one full byte on the line, starting in the clock after the load.
  task automatic stream_byte(input int s, input logic [7:0] b, input logic valid_first,
                             input int chg_at, input logic [7:0] chg_val);
    int unsigned os;
    logic [10:0] o;
    os = (s == 0) ? 1 : 4;
    for (int j = 0; j < 8 * int'(os); j++) begin
      o = obs(s);
      check("ser_bit", o[10], b[7 - j / int'(os)]);
      check("ser_frame", o[9], (j / int'(os)) == 0);
      check("des_valid_in_byte", o[8], (j == 0) && valid_first);
      if (j == chg_at) set_din(s, chg_val);
      tick();
    end
  endtask

  task automatic check_all_zero(input int s, input string tag);
    logic [10:0] o;
    o = obs(s);
    check(tag, o, 11'h000);
  endtask

  always @(negedge clock) begin
    logic [7:0] e;
    if (dv1) begin
      total++;
      assert (q1.size() != 0) else begin
        bad++;
        $error("FAIL sb1_unexpected observed=%0h expected=none", dby1);
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("sb1_byte", dby1, e);
      end
    end
    if (dv4) begin
      total++;
      assert (q4.size() != 0) else begin
        bad++;
        $error("FAIL sb4_unexpected observed=%0h expected=none", dby4);
      end
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check("sb4_byte", dby4, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [10:0] o;
    rst1 = 1'b1; en1 = 1'b0; den1 = 1'b0; din1 = 8'h00;
    rst4 = 1'b1; en4 = 1'b0; den4 = 1'b0; din4 = 8'h00;
    tick();
    tick();
    check_all_zero(0, "reset_os1");
    check_all_zero(1, "reset_os4");
    rst1 = 1'b0;
    rst4 = 1'b0;
    tick();

    // OVERSAMPLE=1: BB then 5A back-to-back, data_in changed mid-byte.
    set_din(0, 8'hBB);
    set_en(0, 1'b1);
    tick();
    set_den(0, 1'b1);
    q1.push_back(8'hBB);
    q1.push_back(8'h5A);
    stream_byte(0, 8'hBB, 1'b0, 3, 8'h5A);
    check("os1_first_valid", dv1, 1'b1);
    check("os1_first_byte", dby1, 8'hBB);
    stream_byte(0, 8'h5A, 1'b1, -1, 8'h00);
    check("os1_second_valid", dv1, 1'b1);
    check("os1_second_byte", dby1, 8'h5A);

    // Disable both sides and idle for 100 clocks.
    set_en(0, 1'b0);
    set_den(0, 1'b0);
    tick();
    for (int i = 0; i < 100; i++) begin
      o = obs(0);
      check("idle_line", o[10:8], 3'b000);
      tick();
    end
    check("idle_hold", dby1, 8'h5A);

    // Reset in the middle of a byte (bit 4 on the line).
    set_din(0, 8'hBB);
    set_en(0, 1'b1);
    tick();
    set_den(0, 1'b1);
    tick();
    tick();
    tick();
    check("midbyte_line_bit4", dout1, 1'b1);
    set_rst(0, 1'b1);
    tick();
    check_all_zero(0, "midbyte_reset");
    set_en(0, 1'b0);
    set_den(0, 1'b0);
    tick();
    set_rst(0, 1'b0);
    tick();

    // Restart after reset.
    set_en(0, 1'b1);
    tick();
    set_den(0, 1'b1);
    q1.push_back(8'hBB);
    stream_byte(0, 8'hBB, 1'b0, -1, 8'h00);
    check("restart_valid", dv1, 1'b1);
    check("restart_byte", dby1, 8'hBB);
    set_en(0, 1'b0);
    set_den(0, 1'b0);
    tick();
    tick();

    // OVERSAMPLE=4: same byte, each bit held four clocks.
    set_din(1, 8'hBB);
    set_en(1, 1'b1);
    tick();
    set_den(1, 1'b1);
    q4.push_back(8'hBB);
    stream_byte(1, 8'hBB, 1'b0, -1, 8'h00);
    check("os4_valid", dv4, 1'b1);
    check("os4_byte", dby4, 8'hBB);
    set_en(1, 1'b0);
    set_den(1, 1'b0);
    tick();
    tick();

    // OVERSAMPLE=4 with des_enable one bit late: rotated byte, no realignment.
    set_rst(1, 1'b1);
    tick();
    set_rst(1, 1'b0);
    set_en(1, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) tick();
    set_den(1, 1'b1);
    q4.push_back(8'h77);
    n = 0;
    while (!dv4 && n < 100) begin
      tick();
      n++;
    end
    check("rot_latency", n, 32);
    check("rot_byte", dby4, 8'h77);
    set_en(1, 1'b0);
    set_den(1, 1'b0);
    tick();
    tick();

    check("q1_drained", q1.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
